or1200_pcu_gen: RTL and testbench
=================================

Name: or1200_pcu_gen

Overview:
- Parametrised performance counter unit: NUM_CNT counters of CNT_WIDTH bits, each counting any OR-combination of NUM_EVENTS event inputs.
- Each counter has its own mode register, per-counter privilege filtering, sticky overflow status and an overflow interrupt.
- Sits beside the CPU pipeline on the SPR bus, in the PCU SPR group.
- Adds writable counters, configurable edge/level event detection, overflow status/IRQ and a free-running time counter.

Parameters:
- NUM_CNT, 8, number of counters (1..8).
- CNT_WIDTH, 32, counter width in bits (8..32).
- NUM_EVENTS, 10, number of event inputs (1..16).
- EDGE_MASK, 16'h027F, per event: bit=1 counts rising edges, bit=0 counts every cycle the input is high.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active low
- event_i  in  NUM_EVENTS  raw event strobes from LSU/IF/caches/TLBs
- supv_i  in  1  CPU in supervisor mode
- du_stall_i  in  1  debug-unit stall (used only with the freeze feature)
- spr_cs_i  in  1  SPR access targets the PCU group
- spr_write_i  in  1  1 = write, 0 = read
- spr_addr_i  in  5  offset within the PCU group
- spr_dat_i  in  32  write data
- spr_dat_o  out  32  read data, registered
- pcu_irq_o  out  1  overflow interrupt, registered
- pcu_cnt_o  out  32  free-running cycle counter

Behaviour:
- Reset: clk is the only clock; rst is asynchronous and active-low. On reset:
  - all counters = 0; PCSR = 0; all PCMR = 32'h1; event history = 0
  - spr_dat_o = 0; pcu_irq_o = 0; pcu_cnt_o = 0
- Register map:
  - offsets 0..7: PCCR0..7 (counters)
  - offsets 8..15: PCMR0..7 (mode registers)
  - offset 16: PCSR (status)
  - offset 17: PCTR (read-only, returns pcu_cnt_o)
  - indices >= NUM_CNT and other offsets read 0 and ignore writes.
- PCMR fields:
  - bit0 EN
  - bit1 OVIE (overflow interrupt enable)
  - bit2 count in user mode; bit3 count in supervisor mode
  - bits[4+NUM_EVENTS-1:4] event mask
  - other bits read 0
- Event conditioning: cond[e] = EDGE_MASK[e] ? (event_i[e] & ~event_q[e]) : event_i[e]. event_q is the previous-cycle value of event_i.
- Increment rule: counter i increments by exactly 1 in a cycle when all of the following hold:
  - EN = 1
  - mode matches: (supv_i & bit3) | (~supv_i & bit2)
  - |(mask & cond) = 1
- Multiple coincident events still add 1.
- EN = 0: counter holds its value; it is not cleared.
- Overflow: incrementing from all-ones wraps to 0 and sets PCSR[i] in the same edge.
- PCSR:
  - bits[NUM_CNT-1:0] sticky overflow flags, write-1-to-clear
  - a set and a clear of the same bit in the same cycle: set wins
- IRQ: pcu_irq_o <= |(PCSR & OVIE), one cycle after the flag is set. It stays high until the flag is cleared or OVIE = 0.
- SPR write:
  - takes effect at the next clk edge when spr_cs_i & spr_write_i
  - a PCCR write truncates to CNT_WIDTH and takes priority over a same-cycle increment; no overflow is flagged
- SPR read:
  - spr_dat_o is updated one cycle after spr_cs_i & ~spr_write_i
  - counters are zero-extended on read
  - when spr_cs_i = 0 or on a write cycle, spr_dat_o <= 0
- pcu_cnt_o increments every cycle and wraps at 2^32.
- Reset asserted mid-operation clears all state immediately (asynchronous); there is no partial-write recovery.

Optional Feature:
- Macro: OR1200_PCU_FREEZE_EN.
- Defined:
  - PCSR bit31 = FOV (freeze-on-overflow), read/write.
  - When FOV = 1 and any PCSR overflow flag is set, all counter increments are suppressed.
  - du_stall_i = 1 also suppresses all counter increments.
  - SPR writes still apply; pcu_cnt_o keeps running.
- Undefined:
  - du_stall_i is ignored.
  - PCSR bit31 reads 0 and writes to it are dropped.

Decomposition:
- Shared include or1200_pcu_defs holds:
  - SPR offsets (PCCR base 0, PCMR base 8, PCSR 16, PCTR 17)
  - PCMR field positions (EN, OVIE, UM, SM, MASK_LSB)
  - PCSR FOV bit position
- One sub-module or1200_pcu_cnt is instantiated NUM_CNT times. Each instance owns:
  - its counter, mode register and overflow-detect logic
  - increment/write/hold priority
- Event conditioning, PCSR, IRQ, read mux and time counter live in the top module.

Test Plan:
- Increment counting: PCMR0 = EN|SM|mask bit0; supv_i = 1; pulse event_i[0] high for 5 cycles (edge-type) → PCCR0 = 1. Same test on level event 7 held 5 cycles → 5.
- Privilege filter: PCMR1 = EN|UM|mask bit2; supv_i = 1 with 10 event_i[2] edges → PCCR1 = 0. Repeat with supv_i = 0 → PCCR1 = 10.
- Overflow and IRQ: CNT_WIDTH = 8; write PCCR2 = 8'hFF; OVIE = 1; one event → PCCR2 = 0, PCSR[2] = 1, pcu_irq_o = 1 one cycle later. Write PCSR = 4 → flag and IRQ clear.
- Collisions: PCCR write coincident with an increment → written value is read back. PCSR clear coincident with a new overflow → flag remains 1.
- Read timing: read PCTR → spr_dat_o is valid the cycle after spr_cs_i. Read offset 5 with NUM_CNT = 4 → 0. Assert rst low mid-count → all outputs 0 with no clock edge.
- Freeze (macro defined): FOV = 1 and PCSR[0] set → no counter moves. du_stall_i = 1 → no counter moves. With the macro undefined → counters advance.

Source files
------------

// File: rtl/or1200_pcu_gen_pkg.sv
// Shared definitions for the performance counter unit (the or1200_pcu_defs set):
// SPR offsets inside the PCU group, PCMR field positions, PCSR FOV position,
// and a small address decoder used by the top-level register file.
package or1200_pcu_gen_pkg;

  // SPR offsets within the PCU group
  localparam logic [4:0] PCCR_BASE = 5'd0;
  localparam logic [4:0] PCMR_BASE = 5'd8;
  localparam logic [4:0] PCSR_ADDR = 5'd16;
  localparam logic [4:0] PCTR_ADDR = 5'd17;

  // PCMR field positions
  localparam int PCMR_EN       = 0;
  localparam int PCMR_OVIE     = 1;
  localparam int PCMR_UM       = 2;
  localparam int PCMR_SM       = 3;
  localparam int PCMR_MASK_LSB = 4;

  // PCSR freeze-on-overflow bit
  localparam int PCSR_FOV = 31;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_PCCR,
    SEL_PCMR,
    SEL_PCSR,
    SEL_PCTR
  } spr_sel_e;

  // Offsets 0..7 and 8..15 are banks of eight; the low three bits index the bank.
  function automatic spr_sel_e spr_decode(input logic [4:0] addr);
    spr_sel_e sel;
    sel = SEL_NONE;
    if ((addr & 5'b11000) == PCCR_BASE)      sel = SEL_PCCR;
    else if ((addr & 5'b11000) == PCMR_BASE) sel = SEL_PCMR;
    else if (addr == PCSR_ADDR)              sel = SEL_PCSR;
    else if (addr == PCTR_ADDR)              sel = SEL_PCTR;
    return sel;
  endfunction

endpackage

// File: rtl/or1200_pcu_gen_if.sv
// SPR bus slice seen by the performance counter unit.
// Protocol: single-cycle access with no ready/valid back-pressure. A cycle with
// spr_cs_i=1 is one access; spr_write_i selects write (applied at the next clk
// edge) or read (spr_dat_o carries the data in the cycle after the access, and
// is 0 after any non-read cycle).
// Modports: master drives the request, slave (the PCU) returns spr_dat_o.
interface or1200_pcu_gen_if;
  logic        spr_cs_i;
  logic        spr_write_i;
  logic [4:0]  spr_addr_i;
  logic [31:0] spr_dat_i;
  logic [31:0] spr_dat_o;

  modport master (output spr_cs_i, spr_write_i, spr_addr_i, spr_dat_i,
                  input  spr_dat_o);
  modport slave  (input  spr_cs_i, spr_write_i, spr_addr_i, spr_dat_i,
                  output spr_dat_o);
endinterface

// File: rtl/or1200_pcu_cnt.sv
// One performance counter: counter register, its mode register (PCMR), the
// increment/write/hold priority and overflow detection.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   cond_i          conditioned events (edge/level already applied)
//   supv_i          CPU in supervisor mode
//   freeze_i        suppress increments this cycle
//   cnt_we_i/cnt_wdata_i  PCCR write
//   mr_we_i/mr_wdata_i    PCMR write
//   cnt_o, mr_o     current counter / mode register
//   ovf_o           this edge wraps the counter from all-ones to zero
module or1200_pcu_cnt
  import or1200_pcu_gen_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int NUM_EVENTS = 10
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_EVENTS-1:0]                cond_i,
  input  logic                                 supv_i,
  input  logic                                 freeze_i,
  input  logic                                 cnt_we_i,
  input  logic [CNT_WIDTH-1:0]                 cnt_wdata_i,
  input  logic                                 mr_we_i,
  input  logic [PCMR_MASK_LSB+NUM_EVENTS-1:0]  mr_wdata_i,
  output logic [CNT_WIDTH-1:0]                 cnt_o,
  output logic [PCMR_MASK_LSB+NUM_EVENTS-1:0]  mr_o,
  output logic                                 ovf_o
);

  localparam int MR_W = PCMR_MASK_LSB + NUM_EVENTS;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [MR_W-1:0]      mr_q;
  logic                 mode_ok;
  logic                 hit;
  logic                 inc;

  assign mode_ok = (supv_i & mr_q[PCMR_SM]) | (~supv_i & mr_q[PCMR_UM]);
  // Any number of coincident selected events still adds exactly one.
  assign hit     = |(mr_q[MR_W-1:PCMR_MASK_LSB] & cond_i);
  assign inc     = mr_q[PCMR_EN] & mode_ok & hit & ~freeze_i;
  // A software write wins over the increment, so it never flags overflow.
  assign ovf_o   = inc & ~cnt_we_i & (&cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      mr_q  <= MR_W'(1);
    end else begin
      if (mr_we_i) mr_q <= mr_wdata_i;
      if (cnt_we_i)  cnt_q <= cnt_wdata_i;
      else if (inc)  cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o = cnt_q;
  assign mr_o  = mr_q;

endmodule

// File: rtl/or1200_pcu_gen.sv
// Performance counter unit on the SPR bus: NUM_CNT counters of CNT_WIDTH bits
// counting OR-combinations of NUM_EVENTS event inputs, sticky overflow status
// (PCSR, write-1-to-clear), overflow interrupt and a free-running cycle counter.
// Optional feature macro OR1200_PCU_FREEZE_EN: adds PCSR.FOV (freeze all
// counters while any overflow flag is set) and du_stall_i freezing.
// Ports:
//   clk, rst       clock, asynchronous active-low reset
//   event_i        raw event strobes
//   supv_i         CPU in supervisor mode
//   du_stall_i     debug-unit stall (freeze feature only)
//   spr            SPR bus (slave modport), registered read data
//   pcu_irq_o      registered overflow interrupt
//   pcu_cnt_o      free-running cycle counter (PCTR)
module or1200_pcu_gen
  import or1200_pcu_gen_pkg::*;
#(
  parameter int          NUM_CNT    = 8,
  parameter int          CNT_WIDTH  = 32,
  parameter int          NUM_EVENTS = 10,
  parameter logic [15:0] EDGE_MASK  = 16'h027F
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic                  supv_i,
  input  logic                  du_stall_i,
  or1200_pcu_gen_if.slave       spr,
  output logic                  pcu_irq_o,
  output logic [31:0]           pcu_cnt_o
);

  localparam int MR_W = PCMR_MASK_LSB + NUM_EVENTS;

  spr_sel_e              sel;
  logic [2:0]            idx;
  logic                  wr_en;
  logic                  rd_en;
  logic [NUM_EVENTS-1:0] event_q;
  logic [NUM_EVENTS-1:0] cond;
  logic                  freeze;
  logic                  pcsr_fov;
  logic [7:0]            pcsr_ovf;
  logic [7:0]            clr;
  logic [7:0]            ovf;
  logic [7:0]            ovie;
  logic [CNT_WIDTH-1:0]  cnt_q [8];
  logic [MR_W-1:0]       mr_q  [8];
  logic [31:0]           rdata;
  logic                  unused_in;

  assign sel   = spr_decode(spr.spr_addr_i);
  assign idx   = spr.spr_addr_i[2:0];
  assign wr_en = spr.spr_cs_i & spr.spr_write_i;
  assign rd_en = spr.spr_cs_i & ~spr.spr_write_i;

  // Edge-type events only pass when the previous sample was low.
  assign cond = event_i & ~(event_q & EDGE_MASK[NUM_EVENTS-1:0]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) event_q <= '0;
    else      event_q <= event_i;
  end

`ifdef OR1200_PCU_FREEZE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           pcsr_fov <= 1'b0;
    else if (wr_en && sel == SEL_PCSR)  pcsr_fov <= spr.spr_dat_i[PCSR_FOV];
  end
  assign freeze = du_stall_i | (pcsr_fov & |pcsr_ovf);
`else
  assign pcsr_fov = 1'b0;
  assign freeze   = 1'b0;
`endif

  // Not every build consumes every input bit.
  assign unused_in = ^{du_stall_i, spr.spr_dat_i};

  // Always eight slots so the 3-bit index needs no range check; slots at or
  // above NUM_CNT are tied to zero and read back as 0.
  for (genvar gi = 0; gi < 8; gi++) begin : g_cnt
    if (gi < NUM_CNT) begin : g_on
      or1200_pcu_cnt #(
        .CNT_WIDTH  (CNT_WIDTH),
        .NUM_EVENTS (NUM_EVENTS)
      ) u_cnt (
        .clk         (clk),
        .rst         (rst),
        .cond_i      (cond),
        .supv_i      (supv_i),
        .freeze_i    (freeze),
        .cnt_we_i    (wr_en && sel == SEL_PCCR && idx == 3'(gi)),
        .cnt_wdata_i (spr.spr_dat_i[CNT_WIDTH-1:0]),
        .mr_we_i     (wr_en && sel == SEL_PCMR && idx == 3'(gi)),
        .mr_wdata_i  (spr.spr_dat_i[MR_W-1:0]),
        .cnt_o       (cnt_q[gi]),
        .mr_o        (mr_q[gi]),
        .ovf_o       (ovf[gi])
      );
    end else begin : g_off
      assign cnt_q[gi] = '0;
      assign mr_q[gi]  = '0;
      assign ovf[gi]   = 1'b0;
    end
    assign ovie[gi] = mr_q[gi][PCMR_OVIE];
  end

  // Set has priority over a same-cycle write-1-to-clear.
  assign clr = (wr_en && sel == SEL_PCSR) ? spr.spr_dat_i[7:0] : 8'h00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcsr_ovf  <= '0;
      pcu_irq_o <= 1'b0;
      pcu_cnt_o <= '0;
    end else begin
      pcsr_ovf  <= (pcsr_ovf & ~clr) | ovf;
      pcu_irq_o <= |(pcsr_ovf & ovie);
      pcu_cnt_o <= pcu_cnt_o + 32'd1;
    end
  end

  always_comb begin
    rdata = '0;
    case (sel)
      SEL_PCCR: rdata = 32'(cnt_q[idx]);
      SEL_PCMR: rdata = 32'(mr_q[idx]);
      SEL_PCSR: begin
        rdata[7:0]      = pcsr_ovf;
        rdata[PCSR_FOV] = pcsr_fov;
      end
      SEL_PCTR: rdata = pcu_cnt_o;
      default:  rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       spr.spr_dat_o <= '0;
    else if (rd_en) spr.spr_dat_o <= rdata;
    else            spr.spr_dat_o <= '0;
  end

endmodule

// File: tb/tb_or1200_pcu_gen.sv
module tb_or1200_pcu_gen;

  localparam int          NC     = 4;
  localparam int          CW     = 8;
  localparam int          NE     = 10;
  localparam logic [15:0] EDGE_M = 16'h027F;
  localparam int          CMAX   = (1 << CW) - 1;
  localparam logic [31:0] MR_MSK = (32'd1 << (4 + NE)) - 32'd1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NE-1:0] event_i;
  logic          supv_i;
  logic          du_stall_i;
  logic          pcu_irq_o;
  logic [31:0]   pcu_cnt_o;

  or1200_pcu_gen_if spr ();

  or1200_pcu_gen #(
    .NUM_CNT    (NC),
    .CNT_WIDTH  (CW),
    .NUM_EVENTS (NE),
    .EDGE_MASK  (EDGE_M)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .event_i    (event_i),
    .supv_i     (supv_i),
    .du_stall_i (du_stall_i),
    .spr        (spr),
    .pcu_irq_o  (pcu_irq_o),
    .pcu_cnt_o  (pcu_cnt_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model (architectural state) ----------------
  int          m_cnt [8];
  logic [31:0] m_mr  [8];
  logic [7:0]  m_flags;
  logic        m_fov;
  logic [31:0] m_time;
  logic [NE-1:0] m_evq;

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_cnt[i] = 0;
      m_mr[i]  = 32'd1;
    end
    m_flags = '0;
    m_fov   = 1'b0;
    m_time  = '0;
    m_evq   = '0;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    int ai;
    ai = int'(a);
    if (ai < 8)   return (ai < NC) ? 32'(m_cnt[ai]) : 32'd0;
    if (ai < 16)  return (ai - 8 < NC) ? m_mr[ai-8] : 32'd0;
    if (ai == 16) return {m_fov, 23'd0, m_flags};
    if (ai == 17) return m_time;
    return 32'd0;
  endfunction

  // driven stimulus
  logic [NE-1:0] drv_ev    = '0;
  logic          drv_supv  = 1'b0;
  logic          drv_stall = 1'b0;
  logic          drv_cs    = 1'b0;
  logic          drv_wr    = 1'b0;
  logic [4:0]    drv_addr  = '0;
  logic [31:0]   drv_dat   = '0;

  task automatic model_step(output logic [31:0] dat, output logic irq);
    logic [NE-1:0] cond;
    logic [7:0]    ovie_v;
    logic [7:0]    set_bits;
    logic          frz, mode_ok, hit;
    ovie_v = '0;
    for (int i = 0; i < NC; i++) ovie_v[i] = m_mr[i][1];
    irq = ((m_flags & ovie_v) != 0);
    dat = (drv_cs && !drv_wr) ? model_read(drv_addr) : 32'd0;
    for (int e = 0; e < NE; e++)
      cond[e] = EDGE_M[e] ? (drv_ev[e] && !m_evq[e]) : drv_ev[e];
    frz = 1'b0;
`ifdef OR1200_PCU_FREEZE_EN
    frz = (m_fov && m_flags != 0) || drv_stall;
`endif
    set_bits = '0;
    for (int i = 0; i < NC; i++) begin
      mode_ok = drv_supv ? m_mr[i][3] : m_mr[i][2];
      hit = 1'b0;
      for (int e = 0; e < NE; e++) if (m_mr[i][4+e] && cond[e]) hit = 1'b1;
      if (drv_cs && drv_wr && int'(drv_addr) == i)
        m_cnt[i] = int'(drv_dat % (CMAX + 1));
      else if (m_mr[i][0] && mode_ok && hit && !frz) begin
        if (m_cnt[i] == CMAX) begin
          m_cnt[i]    = 0;
          set_bits[i] = 1'b1;
        end else begin
          m_cnt[i] = m_cnt[i] + 1;
        end
      end
      if (drv_cs && drv_wr && int'(drv_addr) == 8 + i) m_mr[i] = drv_dat & MR_MSK;
    end
    if (drv_cs && drv_wr && int'(drv_addr) == 16) begin
      m_flags = m_flags & ~drv_dat[7:0];
`ifdef OR1200_PCU_FREEZE_EN
      m_fov = drv_dat[31];
`endif
    end
    m_flags = m_flags | set_bits;
    m_time  = m_time + 32'd1;
    m_evq   = drv_ev;
  endtask

  // ---------------- driver tasks ----------------
  // One clock: drive, advance the model, then compare every observable output.
  task automatic step();
    logic [31:0] e_dat;
    logic        e_irq;
    event_i         = drv_ev;
    supv_i          = drv_supv;
    du_stall_i      = drv_stall;
    spr.spr_cs_i    = drv_cs;
    spr.spr_write_i = drv_wr;
    spr.spr_addr_i  = drv_addr;
    spr.spr_dat_i   = drv_dat;
    model_step(e_dat, e_irq);
    exp_q.push_back(e_dat);
    @(posedge clk);
    #1;
    check("spr_dat_o", spr.spr_dat_o, exp_q.pop_front());
    check("pcu_irq_o", 32'(pcu_irq_o), 32'(e_irq));
    check("pcu_cnt_o", pcu_cnt_o, m_time);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic spr_write(input logic [4:0] a, input logic [31:0] d);
    drv_cs = 1'b1; drv_wr = 1'b1; drv_addr = a; drv_dat = d;
    step();
    drv_cs = 1'b0; drv_wr = 1'b0;
  endtask

  task automatic read_expect(input string tag, input logic [4:0] a, input logic [31:0] v);
    drv_cs = 1'b1; drv_wr = 1'b0; drv_addr = a;
    step();
    drv_cs = 1'b0;
    check(tag, spr.spr_dat_o, v);
  endtask

  task automatic pulse_ev(input int e);
    drv_ev[e] = 1'b1; step();
    drv_ev[e] = 1'b0; step();
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] frz_exp;

  initial begin
    event_i = '0; supv_i = 1'b0; du_stall_i = 1'b0;
    spr.spr_cs_i = 1'b0; spr.spr_write_i = 1'b0; spr.spr_addr_i = '0; spr.spr_dat_i = '0;
    model_reset();
    #2 rst = 1'b0;
    #1;
    check("rst_dat", spr.spr_dat_o, 32'd0);
    check("rst_irq", 32'(pcu_irq_o), 32'd0);
    check("rst_time", pcu_cnt_o, 32'd0);
    #9 rst = 1'b1;

    read_expect("rst_pcmr0", 5'd8, 32'd1);
    read_expect("rst_pcsr", 5'd16, 32'd0);

    // edge-type event 0 held 5 cycles counts once
    drv_supv = 1'b1;
    spr_write(5'd8, 32'h19);
    drv_ev[0] = 1'b1; idle(5); drv_ev[0] = 1'b0;
    read_expect("edge_cnt", 5'd0, 32'd1);

    // level-type event 7 held 5 cycles counts 5
    spr_write(5'd0, 32'd0);
    spr_write(5'd8, 32'h809);
    drv_ev[7] = 1'b1; idle(5); drv_ev[7] = 1'b0;
    read_expect("level_cnt", 5'd0, 32'd5);

    // privilege filter: user-only counter
    spr_write(5'd9, 32'h45);
    for (int k = 0; k < 10; k++) pulse_ev(2);
    read_expect("supv_blocked", 5'd1, 32'd0);
    drv_supv = 1'b0;
    for (int k = 0; k < 10; k++) pulse_ev(2);
    read_expect("user_counts", 5'd1, 32'd10);
    drv_supv = 1'b1;

    // overflow + IRQ
    spr_write(5'd10, 32'h1B);
    spr_write(5'd2, 32'hFF);
    pulse_ev(0);
    check("irq_set", 32'(pcu_irq_o), 32'd1);
    read_expect("ovf_flag", 5'd16, 32'd4);
    read_expect("ovf_wrap", 5'd2, 32'd0);
    spr_write(5'd16, 32'd4);
    idle(2);
    check("irq_clr", 32'(pcu_irq_o), 32'd0);
    read_expect("flag_clr", 5'd16, 32'd0);

    // collision: counter write beats increment
    drv_ev[7] = 1'b1;
    spr_write(5'd0, 32'h142);
    drv_ev[7] = 1'b0;
    read_expect("wr_beats_inc", 5'd0, 32'h42);

    // collision: new overflow beats PCSR clear
    spr_write(5'd2, 32'hFF);
    drv_ev[0] = 1'b1;
    spr_write(5'd16, 32'd4);
    drv_ev[0] = 1'b0;
    read_expect("set_beats_clr", 5'd16, 32'd4);
    spr_write(5'd16, 32'd4);

    // read-only / unmapped locations
    read_expect("pctr", 5'd17, m_time);
    read_expect("pccr5_none", 5'd5, 32'd0);
    read_expect("pcmr5_none", 5'd13, 32'd0);
    read_expect("off20_none", 5'd20, 32'd0);
    spr_write(5'd5, 32'h33);
    read_expect("pccr5_wr_drop", 5'd5, 32'd0);

    // freeze on overflow
`ifdef OR1200_PCU_FREEZE_EN
    frz_exp = 32'd0;
`else
    frz_exp = 32'd3;
`endif
    spr_write(5'd0, 32'd0);
    spr_write(5'd16, 32'h8000_0000);
    spr_write(5'd2, 32'hFF);
    pulse_ev(0);
    drv_ev[7] = 1'b1; idle(3); drv_ev[7] = 1'b0;
    read_expect("fov_freeze", 5'd0, frz_exp);
    spr_write(5'd16, 32'd4);
    spr_write(5'd0, 32'd0);
    drv_stall = 1'b1;
    drv_ev[7] = 1'b1; idle(3); drv_ev[7] = 1'b0;
    drv_stall = 1'b0;
    read_expect("stall_freeze", 5'd0, frz_exp);

    // randomized traffic against the model
    for (int k = 0; k < 600; k++) begin
      int op;
      drv_ev    = NE'($urandom_range(0, (1 << NE) - 1));
      drv_supv  = 1'($urandom_range(0, 1));
      drv_stall = ($urandom_range(0, 7) == 0);
      op = $urandom_range(0, 4);
      drv_cs = 1'b0; drv_wr = 1'b0;
      if (op == 1 || op == 2) begin
        drv_cs = 1'b1; drv_addr = 5'($urandom_range(0, 19));
      end else if (op == 3) begin
        drv_cs = 1'b1; drv_wr = 1'b1;
        case ($urandom_range(0, 2))
          0: begin drv_addr = 5'($urandom_range(0, 7));  drv_dat = $urandom_range(245, 255); end
          1: begin drv_addr = 5'($urandom_range(8, 15)); drv_dat = $urandom(); end
          default: begin drv_addr = 5'($urandom_range(16, 19)); drv_dat = $urandom(); end
        endcase
      end
      step();
    end
    drv_cs = 1'b0; drv_wr = 1'b0; drv_ev = '0; drv_stall = 1'b0;
    for (int a = 0; a < 18; a++) read_expect("final_rd", 5'(a), model_read(5'(a)));

    // asynchronous reset in the middle of counting
    drv_supv = 1'b1;
    spr_write(5'd8, 32'h809);
    drv_ev[7] = 1'b1; idle(4);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_dat", spr.spr_dat_o, 32'd0);
    check("mid_rst_irq", 32'(pcu_irq_o), 32'd0);
    check("mid_rst_time", pcu_cnt_o, 32'd0);
    drv_ev = '0;
    event_i = '0;
    model_reset();
    #3 rst = 1'b1;
    read_expect("post_rst_cnt", 5'd0, 32'd0);
    read_expect("post_rst_pcmr", 5'd8, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
